spi_sample_rx: RTL and testbench



---
 rtl/spi_sample_rx.sv | 184 ++++++++++++++++++
 tb/tb_spi_sample_rx.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_sample_rx.sv
// SPI-slave (mode 0) sample receiver: bytes go into a small FIFO, one word is released per rate tick.
// Define SPI_STATUS_READBACK_EN to shift a status byte out on MISO and clear sticky flags from the host.
module spi_sample_rx #(
  parameter int         FIFO_DEPTH = 4,
  parameter int         RATE_DIV   = 8,
  parameter logic [7:0] RESET_CODE = 8'h80
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       spi_sck,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic [7:0] d_out,
  output logic       d_upd,
  output logic [3:0] fifo_level,
  output logic       ovf,
  output logic       unf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;

  logic [1:0]    sck_sync;
  logic [1:0]    cs_sync;
  logic [1:0]    mosi_sync;
  logic          sck_d;
  logic          sck_s;
  logic          cs_s;
  logic          mosi_s;
  logic          sck_rise;

  logic [2:0]    bit_cnt;
  logic [6:0]    rx_sr;
  logic          byte_done;
  logic [7:0]    push_data;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] fifo_cnt;
  logic          empty;
  logic          full;
  logic          push_ok;
  logic          pop;

  logic [CW-1:0] rate_cnt;
  logic          tick;
  logic          primed;
  logic          ovf_set;
  logic          unf_set;
  logic          flag_clr;

  // cs_n synchronizer idles high so reset release never looks like a select
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      sck_sync  <= 2'b00;
      cs_sync   <= 2'b11;
      mosi_sync <= 2'b00;
      sck_d     <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[0], spi_sck};
      cs_sync   <= {cs_sync[0], spi_cs_n};
      mosi_sync <= {mosi_sync[0], spi_mosi};
      sck_d     <= sck_s;
    end
  end

  assign sck_s    = sck_sync[1];
  assign cs_s     = cs_sync[1];
  assign mosi_s   = mosi_sync[1];
  assign sck_rise = sck_s & ~sck_d;

  assign byte_done = sck_rise & ~cs_s & (bit_cnt == 3'd7);
  assign push_data = {rx_sr, mosi_s};

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      bit_cnt <= 3'd0;
      rx_sr   <= 7'd0;
    end else if (cs_s) begin
      bit_cnt <= 3'd0;
    end else if (sck_rise) begin
      rx_sr   <= {rx_sr[5:0], mosi_s};
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

  assign fifo_cnt   = wr_ptr - rd_ptr;
  assign fifo_level = 4'(fifo_cnt);
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  assign tick    = (rate_cnt == CW'(RATE_DIV - 1));
  assign pop     = tick & ~empty;
  // a pop in the same cycle frees the slot, so a push at full is still accepted
  assign push_ok = byte_done & (~full | pop);
  assign ovf_set = byte_done & full & ~pop;
  assign unf_set = tick & empty & primed;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rate_cnt <= '0;
      primed   <= 1'b0;
      d_out    <= RESET_CODE;
      d_upd    <= 1'b0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
    end else begin
      rate_cnt <= tick ? '0 : rate_cnt + 1'b1;
      d_upd    <= pop;
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
        primed <= 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        d_out  <= mem[rd_ptr[AW-1:0]];
      end
      ovf <= ovf_set | (ovf & ~flag_clr);
      unf <= unf_set | (unf & ~flag_clr);
    end
  end

`ifdef SPI_STATUS_READBACK_EN
  logic       cs_d;
  logic       cs_fall;
  logic       cs_rise;
  logic       sck_fall;
  logic [7:0] tx_sr;
  logic [2:0] tx_cnt;
  logic       byte_seen;
  logic [7:0] status;

  assign cs_fall  = ~cs_s & cs_d;
  assign cs_rise  = cs_s & ~cs_d;
  assign sck_fall = ~sck_s & sck_d & ~cs_s;
  assign status   = {ovf, unf, primed, 1'b0, fifo_level};
  // flags only clear when the host clocked a whole byte, i.e. it really saw the status
  assign flag_clr = cs_rise & byte_seen;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cs_d      <= 1'b1;
      tx_sr     <= 8'd0;
      tx_cnt    <= 3'd0;
      byte_seen <= 1'b0;
    end else begin
      cs_d <= cs_s;
      if (cs_fall) begin
        tx_sr     <= status;
        tx_cnt    <= 3'd0;
        byte_seen <= 1'b0;
      end else begin
        if (sck_fall) begin
          tx_sr  <= (tx_cnt == 3'd7) ? status : {tx_sr[6:0], 1'b0};
          tx_cnt <= tx_cnt + 3'd1;
        end
        if (byte_done) begin
          byte_seen <= 1'b1;
        end
      end
    end
  end

  assign spi_miso    = tx_sr[7];
  assign spi_miso_oe = ~cs_s;
`else
  assign flag_clr    = 1'b0;
  assign spi_miso    = 1'b0;
  assign spi_miso_oe = 1'b0;
`endif

endmodule

// File: tb/tb_spi_sample_rx.sv
// Directed bench for spi_sample_rx: a RATE_DIV=8 instance and a RATE_DIV=256 instance share the SPI wires.
// Readback expectations follow SPI_STATUS_READBACK_EN when it is defined for the build.
module tb_spi_sample_rx;

`ifdef SPI_STATUS_READBACK_EN
  localparam logic RB_EN = 1'b1;
`else
  localparam logic RB_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       spi_sck = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_mosi = 1'b0;

  logic       f_miso, f_oe, f_dupd, f_ovf, f_unf;
  logic [7:0] f_dout;
  logic [3:0] f_level;
  logic       s_miso, s_oe, s_dupd, s_ovf, s_unf;
  logic [7:0] s_dout;
  logic [3:0] s_level;

  int         cyc;
  int         total = 0;
  int         bad = 0;
  int         f_peak;
  logic [7:0] f_vals[$];
  int         f_cycs[$];
  logic [7:0] s_vals[$];
  logic [7:0] rd_byte;
  logic [7:0] bytes_a[3];

  spi_sample_rx #(.FIFO_DEPTH(4), .RATE_DIV(8), .RESET_CODE(8'h80)) dut_fast (
    .clk(clk), .rst_b(rst_b), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(f_miso), .spi_miso_oe(f_oe), .d_out(f_dout), .d_upd(f_dupd),
    .fifo_level(f_level), .ovf(f_ovf), .unf(f_unf)
  );

  spi_sample_rx #(.FIFO_DEPTH(4), .RATE_DIV(256), .RESET_CODE(8'h80)) dut_slow (
    .clk(clk), .rst_b(rst_b), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(s_miso), .spi_miso_oe(s_oe), .d_out(s_dout), .d_upd(s_dupd),
    .fifo_level(s_level), .ovf(s_ovf), .unf(s_unf)
  );

  always #5 clk = ~clk;

  // cyc equals the DUT rate counter value (mod RATE_DIV) after each edge
  always @(posedge clk) begin
    if (!rst_b) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (rst_b) begin
      if (f_dupd) begin
        f_vals.push_back(f_dout);
        f_cycs.push_back(cyc);
      end
      if (s_dupd) s_vals.push_back(s_dout);
      if (int'(f_level) > f_peak) f_peak = int'(f_level);
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_b    = 1'b0;
    spi_sck  = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_b = 1'b1;
    f_vals.delete();
    f_cycs.delete();
    s_vals.delete();
    f_peak = 0;
  endtask

  task automatic spi_bit(input logic b, input int half);
    spi_mosi = b;
    wait_cyc(half);
    spi_sck = 1'b1;
    wait_cyc(half);
    spi_sck = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) spi_bit(v[i], 2);
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    wait_cyc(2);
  endtask

  task automatic cs_high();
    spi_cs_n = 1'b1;
    wait_cyc(4);
  endtask

  task automatic wait_fast(input int n, input int max_cyc);
    int k = 0;
    while (f_vals.size() < n && k < max_cyc) begin
      wait_cyc(1);
      k++;
    end
  endtask

  task automatic wait_slow(input int n, input int max_cyc);
    int k = 0;
    while (s_vals.size() < n && k < max_cyc) begin
      wait_cyc(1);
      k++;
    end
  endtask

  task automatic wait_to_cycle(input int n);
    while (cyc < n) wait_cyc(1);
  endtask

  // slower sck so the resynchronised MISO settles before each sampling edge
  task automatic spi_read(output logic [7:0] v);
    v = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = 1'b0;
      wait_cyc(4);
      v[i] = s_miso;
      spi_sck = 1'b1;
      wait_cyc(4);
      spi_sck = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bytes_a[0] = 8'h12;
    bytes_a[1] = 8'h34;
    bytes_a[2] = 8'hAB;

    // reset state and unprimed ticks
    do_reset();
    check_output("rst_dout", 32'(f_dout), 32'h80);
    check_output("rst_level", 32'(f_level), 32'h0);
    check_output("rst_ovf", 32'(f_ovf), 32'h0);
    check_output("rst_unf", 32'(f_unf), 32'h0);
    check_output("rst_dupd", 32'(f_dupd), 32'h0);
    check_output("rst_miso", 32'(f_miso), 32'h0);
    check_output("rst_oe", 32'(f_oe), 32'h0);
    check_output("rst_slow_dout", 32'(s_dout), 32'h80);
    wait_cyc(160);
    check_output("idle_no_upd", 32'(f_vals.size()), 32'd0);
    check_output("idle_no_unf", 32'(f_unf), 32'h0);

    // basic stream in one cs window
    do_reset();
    cs_low();
    spi_byte(bytes_a[0]);
    check_output("oe_active", 32'(f_oe), 32'(RB_EN));
    spi_byte(bytes_a[1]);
    spi_byte(bytes_a[2]);
    cs_high();
    wait_fast(3, 100);
    wait_cyc(10);
    check_output("basic_count", 32'(f_vals.size()), 32'd3);
    for (int i = 0; i < 3; i++) check_output($sformatf("basic_val%0d", i), 32'(f_vals[i]), 32'(bytes_a[i]));
    check_output("basic_space01", 32'((f_cycs[1] - f_cycs[0]) % 8), 32'd0);
    check_output("basic_space12", 32'((f_cycs[2] - f_cycs[1]) % 8), 32'd0);
    check_output("basic_dout", 32'(f_dout), 32'hAB);

    // partial byte discarded on cs_n high
    do_reset();
    cs_low();
    for (int i = 0; i < 5; i++) spi_bit(1'b1, 2);
    cs_high();
    check_output("partial_level", 32'(f_level), 32'h0);
    cs_low();
    spi_byte(8'h5A);
    cs_high();
    wait_fast(1, 100);
    wait_cyc(10);
    check_output("partial_count", 32'(f_vals.size()), 32'd1);
    check_output("partial_val", 32'(f_vals[0]), 32'h5A);
    check_output("partial_peak", 32'(f_peak), 32'd1);
    check_output("partial_dout", 32'(f_dout), 32'h5A);

    // underflow after the only sample has been consumed
    do_reset();
    cs_low();
    spi_byte(8'h77);
    cs_high();
    wait_fast(1, 100);
    check_output("unf_after_pop", 32'(f_unf), 32'h0);
    wait_cyc(24);
    check_output("unf_set", 32'(f_unf), 32'h1);
    check_output("unf_hold_dout", 32'(f_dout), 32'h77);
    check_output("unf_count", 32'(f_vals.size()), 32'd1);

    // overflow with ticks held off
    do_reset();
    cs_low();
    for (int i = 1; i <= 6; i++) spi_byte(8'(i));
    wait_cyc(3);
    check_output("ovf_set", 32'(s_ovf), 32'h1);
    check_output("ovf_level", 32'(s_level), 32'h4);
    check_output("ovf_no_upd", 32'(s_vals.size()), 32'd0);
    cs_high();
    wait_slow(4, 1200);
    wait_cyc(5);
    check_output("ovf_out_count", 32'(s_vals.size()), 32'd4);
    for (int i = 0; i < 4; i++) check_output($sformatf("ovf_out%0d", i), 32'(s_vals[i]), 32'(i + 1));

    // push into a full FIFO in the same cycle as a tick pop (tick at cyc 255)
    do_reset();
    cs_low();
    spi_byte(8'h11);
    spi_byte(8'h22);
    spi_byte(8'h33);
    spi_byte(8'h44);
    for (int i = 7; i >= 1; i--) spi_bit(i[0] ? 1'b0 : 1'b1, 2);
    spi_mosi = 1'b1;
    wait_to_cycle(253);
    spi_sck = 1'b1;
    wait_cyc(2);
    spi_sck = 1'b0;
    wait_cyc(3);
    check_output("fullpop_ovf", 32'(s_ovf), 32'h0);
    check_output("fullpop_level", 32'(s_level), 32'h4);
    check_output("fullpop_count", 32'(s_vals.size()), 32'd1);
    check_output("fullpop_head", 32'(s_vals[0]), 32'h11);
    cs_high();
    wait_slow(5, 1100);
    wait_cyc(5);
    check_output("fullpop_tail", 32'(s_vals[4]), 32'h55);

    // status readback in the same cs window that overflowed
    do_reset();
    cs_low();
    for (int i = 1; i <= 6; i++) spi_byte(8'(i));
    check_output("rb_oe", 32'(s_oe), 32'(RB_EN));
    spi_read(rd_byte);
    check_output("rb_status", 32'(rd_byte), RB_EN ? 32'hA4 : 32'h00);
    cs_high();
    check_output("rb_ovf_after", 32'(s_ovf), RB_EN ? 32'h0 : 32'h1);
    check_output("rb_unf_after", 32'(s_unf), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
